// File: rtl/obi_rr_arb_pkg.sv
// Shared OBI types and the round-robin pick helper for obi_rr_bank_arbiter.
// rr_pick searches a fixed-width request vector, so any master count up to ARB_MAX_M works.
package obi_rr_arb_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  localparam int ARB_MAX_M           = 16;
  localparam int ARB_IDX_MAX_W       = 4;
  localparam int ARB_MAX_OUTSTANDING = 2;

  typedef logic [$clog2(ARB_MAX_OUTSTANDING+1)-1:0] fifo_cnt_t;

  typedef struct packed {
    logic                     valid;
    logic [ARB_MAX_M-1:0]     onehot;
    logic [ARB_IDX_MAX_W-1:0] idx;
  } rr_pick_t;

  // Walk offsets from high to low so the nearest requester at or after ptr wins.
  function automatic rr_pick_t rr_pick(input logic [ARB_MAX_M-1:0]     req_vec,
                                       input logic [ARB_IDX_MAX_W-1:0] ptr,
                                       input int                       n);
    rr_pick_t                 r;
    int                       k;
    logic [ARB_IDX_MAX_W-1:0] k4;
    r = '0;
    for (int i = ARB_MAX_M - 1; i >= 0; i--) begin
      if (i < n) begin
        k = int'(ptr) + i;
        if (k >= n) k = k - n;
        k4 = k[ARB_IDX_MAX_W-1:0];
        if (req_vec[k4]) begin
          r.valid = 1'b1;
          r.idx   = k4;
        end
      end
    end
    r.onehot[r.idx] = r.valid;
    return r;
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of granted master indices; head selects who receives the next rvalid.
// Pointers and count reset asynchronously; storage is not reset.
module obi_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/obi_rr_bank_arbiter.sv
// Round-robin arbiter sharing one OBI slave among NUM_MASTERS requesters, with in-order response routing.
// Optional per-master stall counters when OBI_RR_ARB_STALL_CNT_EN is defined.
module obi_rr_bank_arbiter
  import obi_rr_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 3,
  parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING,
  parameter int IDX_W           = $clog2(NUM_MASTERS)
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  master_req_i  [NUM_MASTERS],
  output obi_resp_t master_resp_o [NUM_MASTERS],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i,
  output logic      busy_o,
  output logic      err_unexp_rvalid_o
`ifdef OBI_RR_ARB_STALL_CNT_EN
  ,
  output logic [32*NUM_MASTERS-1:0] stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0]     rr_ptr, cand, lock_idx, head_idx;
  logic                 lock_vld;
  logic [ARB_MAX_M-1:0] req_vec;
  rr_pick_t             pick;
  logic                 any_req, full, empty, pop, sreq, hs;
  logic [CNT_W-1:0]     count;
  logic [NUM_MASTERS-1:0] gnt_vec;
  logic                 unused_pick;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM_MASTERS; i++) req_vec[i] = master_req_i[i].req;
  end

  assign pick        = rr_pick(req_vec, ARB_IDX_MAX_W'(rr_ptr), NUM_MASTERS);
  assign unused_pick = ^{pick.onehot, pick.idx};
  assign any_req     = pick.valid;

  // A waiting candidate stays selected until its handshake, even if a nearer master appears.
  assign cand = (lock_vld && master_req_i[lock_idx].req) ? lock_idx : pick.idx[IDX_W-1:0];
  assign pop  = slave_resp_i.rvalid & ~empty;
  assign sreq = any_req & (~full | pop) & ~rst_i;
  assign hs   = sreq & slave_resp_i.gnt;

  always_comb begin
    slave_req_o = '0;
    if (any_req) slave_req_o = master_req_i[cand];
    slave_req_o.req = sreq;
  end

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      master_resp_o[i]        = '0;
      gnt_vec[i]              = hs && (cand == IDX_W'(i));
      master_resp_o[i].gnt    = gnt_vec[i];
      master_resp_o[i].rvalid = pop && (head_idx == IDX_W'(i));
      master_resp_o[i].rdata  = master_resp_o[i].rvalid ? slave_resp_i.rdata : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr             <= '0;
      lock_vld           <= 1'b0;
      lock_idx           <= '0;
      err_unexp_rvalid_o <= 1'b0;
    end else begin
      err_unexp_rvalid_o <= slave_resp_i.rvalid & empty;
      if (hs) begin
        rr_ptr   <= (cand == IDX_W'(NUM_MASTERS - 1)) ? '0 : cand + 1'b1;
        lock_vld <= 1'b0;
      end else if (sreq) begin
        lock_vld <= 1'b1;
        lock_idx <= cand;
      end
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (hs),
    .pop   (pop),
    .wdata (cand),
    .rdata (head_idx),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign busy_o = (count != '0);

`ifdef OBI_RR_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt [NUM_MASTERS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_MASTERS; i++) stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++)
        if (master_req_i[i].req && !gnt_vec[i] && (stall_cnt[i] != 32'hFFFF_FFFF))
          stall_cnt[i] <= stall_cnt[i] + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) stall_cnt_o[32*i +: 32] = stall_cnt[i];
  end
`endif

endmodule

// File: tb/tb_obi_rr_bank_arbiter.sv
// Randomized bench for obi_rr_bank_arbiter against a queue-based reference model.
// Connects and checks stall_cnt_o when OBI_RR_ARB_STALL_CNT_EN is defined.
module tb_obi_rr_bank_arbiter;
  import obi_rr_arb_pkg::*;

  localparam int N  = 3;
  localparam int MO = 2;

  logic      clk = 1'b0;
  logic      rst;
  obi_req_t  mreq  [N];
  obi_resp_t mresp [N];
  obi_req_t  sreq;
  obi_resp_t sresp;
  logic      busy, err;
`ifdef OBI_RR_ARB_STALL_CNT_EN
  logic [32*N-1:0] stall_cnt;
`endif

  obi_rr_bank_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MO)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .master_req_i       (mreq),
    .master_resp_o      (mresp),
    .slave_req_o        (sreq),
    .slave_resp_i       (sresp),
    .busy_o             (busy),
    .err_unexp_rvalid_o (err)
`ifdef OBI_RR_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o        (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          ptr;
  int          waiting;
  int          q[$];
  int          gnt_log[$];
  bit          err_exp;
  bit          pend [N];
  logic [31:0] stall_m [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ptr     = 0;
    waiting = -1;
    err_exp = 1'b0;
    for (int i = 0; i < N; i++) stall_m[i] = '0;
  endtask

  task automatic start_req(input int i, input logic [31:0] addr);
    pend[i]       = 1'b1;
    mreq[i].we    = 1'($urandom);
    mreq[i].be    = 4'($urandom);
    mreq[i].addr  = addr;
    mreq[i].wdata = $urandom;
  endtask

  // One clock: check registered outputs, drive inputs, check combinational outputs, advance model.
  task automatic step(input int p_start, input int p_gnt, input int p_rv);
    int cand;
    bit any, full, pop, sr, hs, mine;
    @(negedge clk);
    check_eq("busy", busy, q.size() != 0);
    check_eq("err_unexp", err, err_exp);
`ifdef OBI_RR_ARB_STALL_CNT_EN
    for (int i = 0; i < N; i++)
      check_eq($sformatf("stall_cnt%0d", i), stall_cnt[32*i +: 32], stall_m[i]);
`endif
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && ($urandom_range(99) < p_start)) start_req(i, $urandom);
      mreq[i].req = pend[i];
    end
    sresp.gnt    = ($urandom_range(99) < p_gnt);
    sresp.rvalid = ($urandom_range(99) < p_rv);
    sresp.rdata  = $urandom;
    #1;
    any = 1'b0;
    for (int i = 0; i < N; i++) any |= pend[i];
    cand = -1;
    if (waiting >= 0 && pend[waiting]) cand = waiting;
    else
      for (int k = 0; k < N; k++)
        if (cand < 0 && pend[(ptr + k) % N]) cand = (ptr + k) % N;
    full = (q.size() == MO);
    pop  = sresp.rvalid && (q.size() > 0);
    sr   = any && (!full || pop);
    hs   = sr && sresp.gnt;
    check_eq("slave_req", sreq.req, sr);
    if (any) begin
      check_eq("slave_addr", sreq.addr, mreq[cand].addr);
      check_eq("slave_fields", {sreq.we, sreq.be, sreq.wdata}, {mreq[cand].we, mreq[cand].be, mreq[cand].wdata});
    end else begin
      check_eq("slave_idle", {sreq.addr, sreq.wdata}, 64'd0);
    end
    for (int i = 0; i < N; i++) begin
      mine = pop && (q[0] == i);
      check_eq($sformatf("gnt%0d", i), mresp[i].gnt, hs && (cand == i));
      check_eq($sformatf("rvalid%0d", i), mresp[i].rvalid, mine);
      check_eq($sformatf("rdata%0d", i), mresp[i].rdata, mine ? sresp.rdata : 32'd0);
    end
    err_exp = sresp.rvalid && (q.size() == 0);
    for (int i = 0; i < N; i++)
      if (pend[i] && !(hs && cand == i) && stall_m[i] != 32'hFFFF_FFFF) stall_m[i]++;
    if (pop) void'(q.pop_front());
    if (hs) begin
      q.push_back(cand);
      gnt_log.push_back(cand);
      ptr       = (cand + 1) % N;
      waiting   = -1;
      pend[cand] = 1'b0;
    end else if (sr) begin
      waiting = cand;
    end
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_slave_req", sreq.req, 1'b0);
    for (int i = 0; i < N; i++) check_eq($sformatf("rst_gnt%0d", i), mresp[i].gnt, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sresp = '0;
    for (int i = 0; i < N; i++) begin
      mreq[i] = '0;
      start_req(i, 32'h1000 * (i + 1));
      mreq[i].req = 1'b1;
    end
    sresp.gnt = 1'b1;
    sresp.rvalid = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_err", err, 1'b0);
    check_eq("reset_slave_req", sreq.req, 1'b0);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("reset_gnt%0d", i), mresp[i].gnt, 1'b0);
      check_eq($sformatf("reset_rvalid%0d", i), mresp[i].rvalid, 1'b0);
    end
    @(posedge clk);
    #2 rst = 1'b0;

    // Fairness: everyone requests continuously, slave always grants and answers.
    gnt_log.delete();
    repeat (6) step(100, 100, 100);
    check_eq("fair_count", gnt_log.size(), 6);
    for (int k = 0; k < 6 && k < gnt_log.size(); k++)
      check_eq($sformatf("fair_seq%0d", k), gnt_log[k], k % 3);

    // Drain, then an unexpected rvalid on an empty FIFO.
    for (int k = 0; k < 20 && (q.size() != 0 || pend[0] || pend[1] || pend[2]); k++) step(0, 100, 100);
    step(0, 0, 0);
    step(0, 0, 100);
    step(0, 0, 0);
    step(0, 0, 0);

    // FIFO full: grants without responses, then pop-and-push.
    for (int i = 0; i < N; i++) start_req(i, 32'h2000 + i);
    repeat (4) step(0, 100, 0);
    step(0, 100, 100);
    step(0, 100, 0);

    // Asynchronous reset with outstanding work; m0 must win first afterwards.
    reset_mid_cycle();
    for (int i = 0; i < N; i++) start_req(i, 32'h3000 + i);
    gnt_log.delete();
    step(0, 100, 0);
    check_eq("post_reset_first", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    for (int k = 0; k < 20 && (q.size() != 0 || pend[0] || pend[1] || pend[2]); k++) step(0, 100, 100);

    // Grant hold: m1 waits, m0 appears mid-wait and must not steal the slot.
    reset_mid_cycle();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    start_req(1, 32'h100);
    step(0, 0, 0);
    step(0, 0, 0);
    start_req(0, 32'h200);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    gnt_log.delete();
    step(0, 100, 0);
    step(0, 100, 100);
    check_eq("hold_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check_eq("hold_first", gnt_log[0], 1);
      check_eq("hold_second", gnt_log[1], 0);
    end

    // Randomized traffic.
    repeat (500) step(35, 60, 45);
    repeat (20) step(0, 100, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obi_rr_bank_arbiter.md
Name: obi_rr_bank_arbiter

Overview:
- Shares one OBI slave port, typically a single RAM bank on the system bus, among NUM_MASTERS OBI requesters.
- Arbitration is work-conserving round-robin with zero-cycle request forwarding.
- Each accepted transaction's master index is tracked in an in-order ID FIFO, so each rvalid/rdata is routed back to the correct requester.
- Sits between the system bus demux outputs and the memory subsystem bank ports.

Parameters:
- NUM_MASTERS, 3, number of OBI requesters (>=2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (>=1).
- IDX_W, $clog2(NUM_MASTERS), width of a master index (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- master_req_i  in  obi_req_t[NUM_MASTERS]  per-master request (req, we, be, addr, wdata).
- master_resp_o  out  obi_resp_t[NUM_MASTERS]  per-master response (gnt, rvalid, rdata).
- slave_req_o  out  obi_req_t  request to the shared slave.
- slave_resp_i  in  obi_resp_t  response from the shared slave.
- busy_o  out  1  high while any transaction is outstanding.
- err_unexp_rvalid_o  out  1  single-cycle pulse when slave rvalid arrives with the ID FIFO empty.

Behaviour:
- One clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset state:
  - rr pointer = 0; ID FIFO empty.
  - busy_o = 0; err_unexp_rvalid_o = 0.
  - All master_resp_o gnt and rvalid = 0.
  - slave_req_o.req = 0 while rst_i is high.
- Arbitration (combinational):
  - Candidate = first master with req=1, searching from the rr pointer upward, modulo NUM_MASTERS.
  - slave_req_o carries the candidate's request fields.
  - slave_req_o.req = any_req & ~fifo_full.
  - If no request is pending, slave_req_o fields = 0.
- Grant:
  - master_resp_o[cand].gnt = slave_resp_i.gnt & slave_req_o.req.
  - All other masters' gnt = 0.
  - Zero added cycles on the request path.
- Handshake commit, on a clock edge where slave req & gnt:
  - Push cand into the ID FIFO.
  - rr pointer <= (cand + 1) mod NUM_MASTERS. Wrap from NUM_MASTERS-1 goes to 0.
  - The pointer does not move without a handshake.
- Request stability:
  - A master holding req without gnt keeps its request.
  - The arbiter may switch the candidate only after a handshake, never mid-wait. The candidate is latched as the "locked" index while req is high and gnt is low (OBI stability rule).
- Response:
  - slave_resp_i.rvalid routes rvalid and rdata to master_resp_o[fifo_head] and pops the FIFO in the same cycle.
  - Non-selected masters see rvalid=0 and rdata=0.
- FIFO boundaries:
  - Full (MAX_OUTSTANDING entries): slave_req_o.req forced to 0 and no gnt, unless a pop occurs that cycle. Pop-and-push in the same cycle when full is allowed; the full decision uses the pre-pop count.
  - Empty: any rvalid is dropped and err_unexp_rvalid_o pulses for 1 cycle.
  - Simultaneous push and pop keeps the count unchanged, order preserved.
- busy_o = (fifo count != 0), registered.
- Reset mid-transaction: FIFO cleared. Responses arriving after reset release are treated as unexpected (dropped, error pulse).

Optional Feature:
- Macro: OBI_RR_ARB_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt_o, width 32*NUM_MASTERS.
  - Contains one 32-bit saturating counter per master.
  - A counter increments each cycle that master has req=1 and gnt=0, and saturates at 32'hFFFF_FFFF.
  - Counters clear on rst_i.
- When undefined: no port and no counters. Behaviour is otherwise identical.

Decomposition:
- Shared package obi_rr_arb_pkg:
  - Function rr_pick(req_vec, ptr) returning a one-hot grant and index.
  - Typedef for the FIFO count, sized $clog2(MAX_OUTSTANDING+1).
- Sub-module obi_arb_id_fifo:
  - Parametric depth and width.
  - Ports: push/pop/data, full/empty/count; asynchronous active-high reset.
  - Instantiated once for in-order response routing.

Test Plan:
- Round-robin fairness: all 3 masters hold req continuously, slave gnt=1 always, rvalid 1 cycle later. Required: grants go 0,1,2,0,1,2 and each rdata returns to the issuing master.
- FIFO full: MAX_OUTSTANDING=2, slave gnt=1, rvalid withheld. Required: two grants (m0, m1), then slave_req_o.req=0 and busy_o=1. First rvalid (rdata=32'hA5A5_0000) goes to m0, then a third grant occurs in the same cycle.
- Grant hold: m1 reqs addr 0x100 with slave gnt=0 for 5 cycles, while m0 raises req at cycle 2. Required: slave_req_o.addr stays 0x100 until the m1 handshake; m0 is granted next.
- Unexpected response: after reset, pulse slave rvalid with an empty FIFO. Required: err_unexp_rvalid_o=1 for exactly 1 cycle and all master rvalid=0.
- Reset mid-operation: 2 outstanding, assert rst_i asynchronously mid-cycle. Required: busy_o=0 immediately, slave req=0, rr pointer=0. After release, m0 is granted first.
- With OBI_RR_ARB_STALL_CNT_EN: m2 waits 7 cycles behind m0/m1 traffic. Required: stall_cnt_o[m2]=7 and the other masters' counts match their wait cycles.
